// File: rtl/unified_mem_arbiter_if.sv
// Memory bus bundle shared by the IF/MEM requesters, the arbiter and the
// downstream memory port.
//
// Handshake: a requester raises its request level (memread / memwrite) and
// holds address, byte enables and write data stable until its resp is 1 for
// one cycle. resp marks completion and qualifies rdata in that same cycle.
// The downstream port follows the same rule, with pmem_read / pmem_write as
// the request level and pmem_resp as the completion pulse.
interface unified_mem_arbiter_if;
    // Instruction-fetch requester (read only)
    logic [15:0] if_memaddr;
    logic        if_memread;
    logic [1:0]  if_mem_byte_enable;
    logic        if_mem_resp;
    logic [15:0] if_mem_rdata;
    // Data-memory requester (read/write)
    logic [15:0] mem_memaddr;
    logic        mem_memread;
    logic        mem_memwrite;
    logic [15:0] mem_mem_wdata;
    logic [1:0]  mem_mem_byte_enable;
    logic        mem_mem_resp;
    logic [15:0] mem_mem_rdata;
    // Downstream memory port
    logic [15:0] pmem_address;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_byte_enable;
    logic        pmem_resp;
    logic [15:0] pmem_rdata;

    // Environment side: both requesters plus the downstream memory
    modport master (
        output if_memaddr, if_memread, if_mem_byte_enable,
        input  if_mem_resp, if_mem_rdata,
        output mem_memaddr, mem_memread, mem_memwrite, mem_mem_wdata, mem_mem_byte_enable,
        input  mem_mem_resp, mem_mem_rdata,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata, pmem_byte_enable,
        output pmem_resp, pmem_rdata
    );

    // Arbiter side
    modport slave (
        input  if_memaddr, if_memread, if_mem_byte_enable,
        output if_mem_resp, if_mem_rdata,
        input  mem_memaddr, mem_memread, mem_memwrite, mem_mem_wdata, mem_mem_byte_enable,
        output mem_mem_resp, mem_mem_rdata,
        output pmem_address, pmem_read, pmem_write, pmem_wdata, pmem_byte_enable,
        input  pmem_resp, pmem_rdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Two-requester (IF read-only, MEM read/write) to one memory port arbiter.
// Transactions are serialised by a three-state FSM; all downstream request
// signals are registered, responses are forwarded combinationally, and a
// saturating counter bounds how long IF can be starved by MEM priority.
module unified_mem_arbiter #(
    parameter int MEM_PRIORITY    = 1,
    parameter int IF_STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    unified_mem_arbiter_if.slave bus,
    output logic [1:0]           o_dbg_state
);
    localparam int            CW      = $clog2(IF_STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(IF_STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_IF  = 2'd1,
        SERVE_MEM = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_starve_cnt;
    logic          r_last_grant_mem;   // 0 = last grant went to IF
    logic [15:0]   r_pmem_address;
    logic          r_pmem_read;
    logic          r_pmem_write;
    logic [15:0]   r_pmem_wdata;
    logic [1:0]    r_pmem_byte_enable;

    logic w_if_pend;
    logic w_mem_pend;
    logic w_grant_if;
    logic w_grant_mem;

    assign w_if_pend  = bus.if_memread;
    assign w_mem_pend = bus.mem_memread | bus.mem_memwrite;

    // Pick the winner among pending requesters; only acted on in IDLE
    always_comb begin
        w_grant_if  = 1'b0;
        w_grant_mem = 1'b0;
        if (w_if_pend && !w_mem_pend) begin
            w_grant_if = 1'b1;
        end else if (!w_if_pend && w_mem_pend) begin
            w_grant_mem = 1'b1;
        end else if (w_if_pend && w_mem_pend) begin
            if (MEM_PRIORITY != 0) begin
                // MEM wins ties until IF has lost IF_STARVE_LIMIT times in a row
                if (r_starve_cnt == LIMIT_C) w_grant_if  = 1'b1;
                else                         w_grant_mem = 1'b1;
            end else begin
                if (r_last_grant_mem) w_grant_if  = 1'b1;
                else                  w_grant_mem = 1'b1;
            end
        end
    end

    // FSM with registered downstream request and arbitration history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state            <= IDLE;
            r_starve_cnt       <= '0;
            r_last_grant_mem   <= 1'b0;
            r_pmem_address     <= 16'h0;
            r_pmem_read        <= 1'b0;
            r_pmem_write       <= 1'b0;
            r_pmem_wdata       <= 16'h0;
            r_pmem_byte_enable <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_if) begin
                        r_pmem_address     <= bus.if_memaddr;
                        r_pmem_byte_enable <= bus.if_mem_byte_enable;
                        r_pmem_wdata       <= 16'h0;
                        r_pmem_read        <= 1'b1;
                        r_pmem_write       <= 1'b0;
                        r_starve_cnt       <= '0;
                        r_last_grant_mem   <= 1'b0;
                        r_state            <= SERVE_IF;
                    end else if (w_grant_mem) begin
                        r_pmem_address     <= bus.mem_memaddr;
                        r_pmem_byte_enable <= bus.mem_mem_byte_enable;
                        r_pmem_wdata       <= bus.mem_mem_wdata;
                        // Read and write together is illegal: forward the write only
                        r_pmem_read        <= bus.mem_memread & ~bus.mem_memwrite;
                        r_pmem_write       <= bus.mem_memwrite;
                        r_last_grant_mem   <= 1'b1;
                        // Only a MEM grant that beats a waiting IF counts as starvation
                        if (w_if_pend && (r_starve_cnt != LIMIT_C)) begin
                            r_starve_cnt <= r_starve_cnt + CW'(1);
                        end
                        r_state            <= SERVE_MEM;
                    end
                end
                SERVE_IF, SERVE_MEM: begin
                    // Request drops during service are ignored; wait for completion
                    if (bus.pmem_resp) begin
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.pmem_address     = r_pmem_address;
    assign bus.pmem_read        = r_pmem_read;
    assign bus.pmem_write       = r_pmem_write;
    assign bus.pmem_wdata       = r_pmem_wdata;
    assign bus.pmem_byte_enable = r_pmem_byte_enable;

    // Completion is steered to whichever requester owns the port; none in IDLE
    assign bus.if_mem_resp   = bus.pmem_resp & (r_state == SERVE_IF);
    assign bus.mem_mem_resp  = bus.pmem_resp & (r_state == SERVE_MEM);
    assign bus.if_mem_rdata  = bus.pmem_rdata;
    assign bus.mem_mem_rdata = bus.pmem_rdata;

    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: instance A uses MEM priority, instance B
// round-robin. A small downstream memory model answers requests after a
// programmable number of cycles with rdata = address ^ 16'hA5A5.
module tb_unified_mem_arbiter;
    localparam int W = 37;   // {port_mem, addr[16], rd, wr, wdata[16], be[2]}

    logic clk;
    logic rst;
    logic [1:0] dbg_state_a;
    logic [1:0] dbg_state_b;

    unified_mem_arbiter_if bus_a ();
    unified_mem_arbiter_if bus_b ();

    unified_mem_arbiter #(.MEM_PRIORITY(1), .IF_STARVE_LIMIT(4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .o_dbg_state(dbg_state_a)
    );
    unified_mem_arbiter #(.MEM_PRIORITY(0), .IF_STARVE_LIMIT(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .o_dbg_state(dbg_state_b)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];

    logic        prev_act[2];
    logic        cur_valid[2];
    logic        cur_port[2];
    logic [15:0] cur_addr[2];
    int          resp_cnt[2];

    int   mem_wait_a;
    logic mem_auto_a;
    logic manual_resp_a;
    int   busy_a;
    int   busy_b;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] mk_exp(input logic port_mem, input logic [15:0] addr,
                                            input logic rd, input logic wr,
                                            input logic [15:0] wdata, input logic [1:0] be);
        return {port_mem, addr, rd, wr, wdata, be};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // downstream memory model for both instances
    initial begin
        bus_a.pmem_resp = 1'b0; bus_a.pmem_rdata = 16'h0;
        bus_b.pmem_resp = 1'b0; bus_b.pmem_rdata = 16'h0;
        busy_a = 0; busy_b = 0;
        forever begin
            @(posedge clk); #1;
            if (!mem_auto_a) begin
                bus_a.pmem_resp = manual_resp_a;
                busy_a = 0;
            end else if (bus_a.pmem_resp) begin
                bus_a.pmem_resp = 1'b0;
                busy_a = 0;
            end else if (bus_a.pmem_read || bus_a.pmem_write) begin
                busy_a++;
                if (busy_a >= mem_wait_a) begin
                    bus_a.pmem_resp  = 1'b1;
                    bus_a.pmem_rdata = bus_a.pmem_address ^ 16'hA5A5;
                end
            end else begin
                busy_a = 0;
            end
            if (bus_b.pmem_resp) begin
                bus_b.pmem_resp = 1'b0;
                busy_b = 0;
            end else if (bus_b.pmem_read || bus_b.pmem_write) begin
                bus_b.pmem_resp  = 1'b1;
                bus_b.pmem_rdata = bus_b.pmem_address ^ 16'hA5A5;
            end
        end
    end

    // scoreboard step: check each new downstream request and each requester resp
    task automatic mon_step(input int s, input logic r, input logic act, input logic [W-2:0] got,
                            input logic if_resp, input logic mem_resp,
                            input logic [15:0] if_rd, input logic [15:0] mem_rd);
        logic [W-1:0] e;
        string tag;
        tag = (s == 0) ? "a" : "b";
        if (r) begin
            prev_act[s]  = 1'b0;
            cur_valid[s] = 1'b0;
            return;
        end
        if (act && !prev_act[s]) begin
            if ((s == 0 && exp_a_q.size() == 0) || (s == 1 && exp_b_q.size() == 0)) begin
                checks++; failures++;
                $display("FAIL unexpected_req_%s got=%0h exp=none", tag, got);
            end else begin
                if (s == 0) e = exp_a_q.pop_front();
                else        e = exp_b_q.pop_front();
                chk({"req_", tag}, {27'h0, got}, {27'h0, e[W-2:0]});
                cur_port[s]  = e[W-1];
                cur_addr[s]  = e[35:20];
                cur_valid[s] = 1'b1;
            end
        end
        if (if_resp || mem_resp) begin
            if (!cur_valid[s]) begin
                checks++; failures++;
                $display("FAIL resp_without_grant_%s got=%0b%0b exp=00", tag, mem_resp, if_resp);
            end else begin
                chk({"resp_port_", tag}, {62'h0, mem_resp, if_resp}, cur_port[s] ? 64'h2 : 64'h1);
                chk({"resp_rdata_", tag}, cur_port[s] ? mem_rd : if_rd, cur_addr[s] ^ 16'hA5A5);
                resp_cnt[s]++;
                cur_valid[s] = 1'b0;
            end
        end
        prev_act[s] = act;
    endtask

    // monitor
    always @(negedge clk) begin
        mon_step(0, rst, bus_a.pmem_read | bus_a.pmem_write,
                 {bus_a.pmem_address, bus_a.pmem_read, bus_a.pmem_write, bus_a.pmem_wdata, bus_a.pmem_byte_enable},
                 bus_a.if_mem_resp, bus_a.mem_mem_resp, bus_a.if_mem_rdata, bus_a.mem_mem_rdata);
        mon_step(1, rst, bus_b.pmem_read | bus_b.pmem_write,
                 {bus_b.pmem_address, bus_b.pmem_read, bus_b.pmem_write, bus_b.pmem_wdata, bus_b.pmem_byte_enable},
                 bus_b.if_mem_resp, bus_b.mem_mem_resp, bus_b.if_mem_rdata, bus_b.mem_mem_rdata);
    end

    // driver tasks
    task automatic drop_a();
        bus_a.if_memaddr = 16'h0; bus_a.if_memread = 1'b0; bus_a.if_mem_byte_enable = 2'b00;
        bus_a.mem_memaddr = 16'h0; bus_a.mem_memread = 1'b0; bus_a.mem_memwrite = 1'b0;
        bus_a.mem_mem_wdata = 16'h0; bus_a.mem_mem_byte_enable = 2'b00;
    endtask

    task automatic drop_b();
        bus_b.if_memaddr = 16'h0; bus_b.if_memread = 1'b0; bus_b.if_mem_byte_enable = 2'b00;
        bus_b.mem_memaddr = 16'h0; bus_b.mem_memread = 1'b0; bus_b.mem_memwrite = 1'b0;
        bus_b.mem_mem_wdata = 16'h0; bus_b.mem_mem_byte_enable = 2'b00;
    endtask

    task automatic chk_zero_a(input string name);
        chk(name, {bus_a.pmem_address, bus_a.pmem_read, bus_a.pmem_write, bus_a.pmem_wdata,
                   bus_a.pmem_byte_enable, bus_a.if_mem_resp, bus_a.mem_mem_resp, dbg_state_a}, 64'h0);
    endtask

    // single transaction on instance A, issued at posedge+1
    task automatic run_txn(input string name, input logic is_mem, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [15:0] wdata, input logic [1:0] be,
                           input logic exp_rd, input logic exp_wr, input int wait_c);
        int lat;
        mem_wait_a = wait_c;
        exp_a_q.push_back(mk_exp(is_mem, addr, exp_rd, exp_wr, is_mem ? wdata : 16'h0, be));
        if (is_mem) begin
            bus_a.mem_memaddr = addr; bus_a.mem_mem_wdata = wdata; bus_a.mem_mem_byte_enable = be;
            bus_a.mem_memread = rd;   bus_a.mem_memwrite = wr;
        end else begin
            bus_a.if_memaddr = addr; bus_a.if_mem_byte_enable = be; bus_a.if_memread = 1'b1;
        end
        lat = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (is_mem ? bus_a.mem_mem_resp : bus_a.if_mem_resp) begin
                lat = t;
                break;
            end
        end
        chk({name, "_lat"}, lat, wait_c);
        @(posedge clk); #1;
        chk({name, "_cleared"}, {bus_a.pmem_read, bus_a.pmem_write}, 2'b00);
        drop_a();
    endtask

    task automatic wait_resps(input int s, input int target, input string name);
        int t = 0;
        while (resp_cnt[s] < target && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk({name, "_count"}, resp_cnt[s], target);
    endtask

    // stimulus
    initial begin
        int base;
        for (int i = 0; i < 2; i++) begin
            prev_act[i] = 1'b0; cur_valid[i] = 1'b0; cur_port[i] = 1'b0;
            cur_addr[i] = 16'h0; resp_cnt[i] = 0;
        end
        mem_wait_a = 1; mem_auto_a = 1'b1; manual_resp_a = 1'b0;
        drop_a(); drop_b();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_a("reset_outputs_a");
        chk("reset_state_b", {bus_b.pmem_read, bus_b.pmem_write, dbg_state_b}, 4'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        run_txn("if_read", 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0, 2'b11, 1'b1, 1'b0, 3);
        run_txn("mem_write", 1'b1, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 2'b01, 1'b0, 1'b1, 2);
        run_txn("mem_read", 1'b1, 1'b1, 1'b0, 16'h0080, 16'h0000, 2'b10, 1'b1, 1'b0, 1);
        run_txn("mem_rw_both", 1'b1, 1'b1, 1'b1, 16'h00C0, 16'h1357, 2'b11, 1'b0, 1'b1, 1);

        // pmem_resp while IDLE must not reach either requester
        @(negedge clk);
        mem_auto_a = 1'b0; manual_resp_a = 1'b1;
        @(posedge clk); #2;
        chk("idle_resp_ignored", {bus_a.pmem_resp, bus_a.if_mem_resp, bus_a.mem_mem_resp}, 3'b100);
        @(negedge clk);
        manual_resp_a = 1'b0;
        @(posedge clk); #2;
        @(negedge clk);
        mem_auto_a = 1'b1;
        @(posedge clk); #1;

        // tie with MEM priority, limit 4: M M M M I M
        base = resp_cnt[0];
        mem_wait_a = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) exp_a_q.push_back(mk_exp(1'b0, 16'h1000, 1'b1, 1'b0, 16'h0, 2'b11));
            else        exp_a_q.push_back(mk_exp(1'b1, 16'h0200, 1'b1, 1'b0, 16'h6666, 2'b11));
        end
        bus_a.if_memaddr = 16'h1000; bus_a.if_mem_byte_enable = 2'b11; bus_a.if_memread = 1'b1;
        bus_a.mem_memaddr = 16'h0200; bus_a.mem_mem_wdata = 16'h6666;
        bus_a.mem_mem_byte_enable = 2'b11; bus_a.mem_memread = 1'b1;
        wait_resps(0, base + 6, "starve");
        drop_a();

        // round-robin on instance B, last grant resets to IF: M I M I
        base = resp_cnt[1];
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) exp_b_q.push_back(mk_exp(1'b1, 16'h0400, 1'b1, 1'b0, 16'h7777, 2'b01));
            else            exp_b_q.push_back(mk_exp(1'b0, 16'h2000, 1'b1, 1'b0, 16'h0, 2'b10));
        end
        bus_b.if_memaddr = 16'h2000; bus_b.if_mem_byte_enable = 2'b10; bus_b.if_memread = 1'b1;
        bus_b.mem_memaddr = 16'h0400; bus_b.mem_mem_wdata = 16'h7777;
        bus_b.mem_mem_byte_enable = 2'b01; bus_b.mem_memread = 1'b1;
        wait_resps(1, base + 4, "round_robin");
        drop_b();

        // reset during SERVE_MEM abandons the transaction
        @(negedge clk);
        mem_auto_a = 1'b0; manual_resp_a = 1'b0;
        @(posedge clk); #1;
        exp_a_q.push_back(mk_exp(1'b1, 16'h0300, 1'b0, 1'b1, 16'h5A5A, 2'b11));
        bus_a.mem_memaddr = 16'h0300; bus_a.mem_mem_wdata = 16'h5A5A;
        bus_a.mem_mem_byte_enable = 2'b11; bus_a.mem_memwrite = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("serve_mem_state", dbg_state_a, 2'd2);
        chk("serve_mem_write", {bus_a.pmem_write, bus_a.pmem_wdata}, {1'b1, 16'h5A5A});
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk_zero_a("async_reset_outputs");
        drop_a();
        manual_resp_a = 1'b1;
        @(posedge clk); #2;
        chk("reset_resp_blocked", {bus_a.pmem_resp, bus_a.if_mem_resp, bus_a.mem_mem_resp}, 3'b100);
        @(negedge clk);
        rst = 1'b0; manual_resp_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_a("after_reset_idle");
        mem_auto_a = 1'b1;

        chk("exp_a_drained", exp_a_q.size(), 0);
        chk("exp_b_drained", exp_b_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
